// File: rtl/fb_write_scheduler_if.sv
// fb_write_scheduler_if: host write, clear control and framebuffer write bundle
interface fb_write_scheduler_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 8
);
    logic              host_valid;
    logic              host_ready;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_data;
    logic              clear_start;
    logic [DATA_W-1:0] clear_color;
    logic              clear_busy;
    logic              clear_done;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;
    modport master (
        output host_valid, host_addr, host_data, clear_start, clear_color,
        input  host_ready, clear_busy, clear_done, mem_we, mem_wa, mem_wd
    );
    modport slave (
        input  host_valid, host_addr, host_data, clear_start, clear_color,
        output host_ready, clear_busy, clear_done, mem_we, mem_wa, mem_wd
    );
endinterface

// File: rtl/fb_write_scheduler.sv
// fb_write_scheduler: merges buffered host writes and a playfield clear onto one write port; FB_VBLANK_ONLY_EN restricts writes to vblank
module fb_write_scheduler #(
    parameter int FB_PIXELS  = 72000,
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    fb_write_scheduler_if.slave          bus,
    input  logic                         vblank_i,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level_o,
    output logic [7:0]                   oor_cnt_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(FB_PIXELS);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(FB_PIXELS - 1);
    localparam logic [PW:0]       FULL  = (PW+1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, CLEAR} state_t;

    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d, head_addr;
    logic [DATA_W-1:0] clr_color_q, clr_color_d, head_data;
    logic              turn_q, turn_d, done_q, done_d;
    logic [7:0]        oor_q, oor_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_wa_q, mem_wa_d;
    logic [DATA_W-1:0] mem_wd_q, mem_wd_d;
    logic              full, empty, accept, in_range, push, permit;
    logic              host_elig, clr_elig, gnt_host, gnt_clr;

    assign level        = wr_ptr_q - rd_ptr_q;
    assign full         = level == FULL;
    assign empty        = level == '0;
    assign head_addr    = fifo_addr_q[rd_ptr_q[PW-1:0]];
    assign head_data    = fifo_data_q[rd_ptr_q[PW-1:0]];
    assign accept       = bus.host_valid && !full;
    assign in_range     = bus.host_addr < LIMIT;
    assign push         = accept && in_range;
`ifdef FB_VBLANK_ONLY_EN
    assign permit       = vblank_i;
`else
    assign permit       = 1'b1;
`endif
    // A queued host write at or beyond the clear pointer waits so the clear can never overwrite it.
    assign host_elig    = !empty && (state_q == IDLE || head_addr < clr_ptr_q);
    assign clr_elig     = state_q == CLEAR;
    assign gnt_host     = permit && host_elig && (!clr_elig || turn_q);
    assign gnt_clr      = permit && clr_elig && (!host_elig || !turn_q);
    assign bus.host_ready = !full;
    assign bus.clear_busy = state_q == CLEAR;
    assign bus.clear_done = done_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_wa     = mem_wa_q;
    assign bus.mem_wd     = mem_wd_q;
    assign fifo_level_o   = level;
    assign oor_cnt_o      = oor_q;

    // Next-state for clear FSM, arbitration turn, FIFO pointers, write port and drop counter.
    always_comb begin
        state_d     = state_q;
        clr_ptr_d   = clr_ptr_q;
        clr_color_d = clr_color_q;
        turn_d      = turn_q;
        done_d      = 1'b0;
        wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = gnt_host ? rd_ptr_q + 1'b1 : rd_ptr_q;
        oor_d       = (accept && !in_range && oor_q != 8'hff) ? oor_q + 8'd1 : oor_q;
        mem_we_d    = gnt_host || gnt_clr;
        mem_wa_d    = gnt_host ? head_addr : clr_ptr_q;
        mem_wd_d    = gnt_host ? head_data : clr_color_q;
        if (state_q == IDLE) begin
            turn_d = 1'b1;
            if (bus.clear_start) begin
                state_d     = CLEAR;
                clr_ptr_d   = '0;
                clr_color_d = bus.clear_color;
            end
        end else begin
            if (host_elig && (gnt_host || gnt_clr))
                turn_d = gnt_clr;
            if (gnt_clr) begin
                state_d   = clr_ptr_q == LAST ? IDLE : CLEAR;
                done_d    = clr_ptr_q == LAST;
                clr_ptr_d = clr_ptr_q == LAST ? clr_ptr_q : clr_ptr_q + 1'b1;
            end
        end
    end

    // Control state and registered write port, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            clr_ptr_q   <= '0;
            clr_color_q <= '0;
            turn_q      <= 1'b1;
            done_q      <= 1'b0;
            oor_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_wa_q    <= '0;
            mem_wd_q    <= '0;
        end else begin
            state_q     <= state_d;
            clr_ptr_q   <= clr_ptr_d;
            clr_color_q <= clr_color_d;
            turn_q      <= turn_d;
            done_q      <= done_d;
            oor_q       <= oor_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_we_q    <= mem_we_d;
            mem_wa_q    <= mem_wa_d;
            mem_wd_q    <= mem_wd_d;
        end
    end

    // FIFO storage; validity is tracked by the pointers so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q[PW-1:0]] <= bus.host_addr;
            fifo_data_q[wr_ptr_q[PW-1:0]] <= bus.host_data;
        end
    end
endmodule

// File: tb/tb_fb_write_scheduler.sv
// tb_fb_write_scheduler: directed checks of host path, drop counter, clear engine and hazard ordering
module tb_fb_write_scheduler;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vblank = 1'b1;
    logic [3:0]  fifo_level;
    logic [7:0]  oor_cnt;
    int          n_chk = 0, n_err = 0;
    int          cyc = 0, wcnt = 0, done_cnt = 0, seq_bad = 0, exp_clr = 0, t50 = -100;
    int          w0, w1, tp, bad;
    logic        seq_on = 1'b0, log_en = 1'b0, clr1000 = 1'b0, h1000_late = 1'b0;
    logic [7:0]  fbm [72000];
    logic [24:0] wq [$];
    int          tq [$];

    fb_write_scheduler_if #(.ADDR_W(17), .DATA_W(8)) bus();

    fb_write_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .vblank_i     (vblank),
        .fifo_level_o (fifo_level),
        .oor_cnt_o    (oor_cnt)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset && bus.mem_we) begin
            wcnt++;
            if (bus.mem_wa < 17'd72000) fbm[bus.mem_wa] = bus.mem_wd;
            if (seq_on && bus.mem_wd == 8'h03) begin
                if (int'(bus.mem_wa) != exp_clr) seq_bad++;
                if (bus.mem_wa == 17'd1000) clr1000 = 1'b1;
                exp_clr++;
            end
            if (bus.mem_wa == 17'd1000 && bus.mem_wd == 8'h22) h1000_late = clr1000;
            if (bus.mem_wa == 17'd50 && bus.mem_wd == 8'h11) t50 = cyc;
            if (log_en) begin
                wq.push_back({bus.mem_wa, bus.mem_wd});
                tq.push_back(cyc);
            end
        end
        if (!reset && bus.clear_done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [16:0] a, input logic [7:0] d);
        bus.host_valid = 1'b1;
        bus.host_addr  = a;
        bus.host_data  = d;
        for (int i = 0; i < 3000 && !bus.host_ready; i++) @(negedge clk);
        chk("push_accept", bus.host_ready, 1);
        @(negedge clk);
        bus.host_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 72000; i++) fbm[i] = 8'h00;
        bus.host_valid  = 1'b1;
        bus.host_addr   = 17'd5;
        bus.host_data   = 8'h02;
        bus.clear_start = 1'b0;
        bus.clear_color = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_ready", bus.host_ready, 1);
        chk("rst_we", bus.mem_we, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_oor", oor_cnt, 0);
        chk("rst_busy", bus.clear_busy, 0);
        chk("rst_done", bus.clear_done, 0);
        bus.host_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        bus.host_valid = 1'b1;
        @(negedge clk);
        bus.host_valid = 1'b0;
        chk("single_we_early", bus.mem_we, 0);
        chk("single_level", fifo_level, 1);
        @(negedge clk);
        chk("single_we", bus.mem_we, 1);
        chk("single_wa", bus.mem_wa, 5);
        chk("single_wd", bus.mem_wd, 8'h02);
        @(negedge clk);
        chk("single_strobe_end", bus.mem_we, 0);
        #1 chk("single_count", wcnt, 1);
        bus.host_valid = 1'b1;
        bus.host_addr  = 17'd72000;
        @(negedge clk);
        bus.host_addr  = 17'd131071;
        @(negedge clk);
        bus.host_valid = 1'b0;
        @(negedge clk);
        chk("oor_two", oor_cnt, 2);
        chk("oor_level", fifo_level, 0);
        bus.host_valid = 1'b1;
        bus.host_addr  = 17'd72000;
        repeat (300) @(negedge clk);
        bus.host_valid = 1'b0;
        chk("oor_sat", oor_cnt, 255);
        #1 chk("oor_no_write", wcnt, 1);
`ifdef FB_VBLANK_ONLY_EN
        vblank = 1'b0;
        log_en = 1'b1;
        for (int i = 0; i < 8; i++) push(17'(200 + i), 8'(8'h50 + i));
        chk("vb_full_ready", bus.host_ready, 0);
        chk("vb_full_level", fifo_level, 8);
        bus.host_valid = 1'b1;
        bus.host_addr  = 17'd208;
        bus.host_data  = 8'h58;
        repeat (3) @(negedge clk);
        #1 chk("vb_no_write", wq.size(), 0);
        chk("vb_held_level", fifo_level, 8);
        vblank = 1'b1;
        for (int i = 0; i < 20 && !bus.host_ready; i++) @(negedge clk);
        @(negedge clk);
        bus.host_valid = 1'b0;
        repeat (12) @(negedge clk);
        #1 chk("vb_drain_count", wq.size(), 9);
        for (int i = 0; i < 9 && i < wq.size(); i++) chk("vb_drain_order", wq[i], {17'(200 + i), 8'(8'h50 + i)});
        if (tq.size() == 9) chk("vb_drain_rate", tq[8] - tq[0], 8);
        log_en = 1'b0;
`endif
        w0 = wcnt;
        seq_on = 1'b1;
        bus.clear_color = 8'h03;
        bus.clear_start = 1'b1;
        @(negedge clk);
        bus.clear_start = 1'b0;
        chk("clr_busy", bus.clear_busy, 1);
        repeat (99) @(negedge clk);
        push(17'd50, 8'h11);
        tp = cyc;
        bus.clear_color = 8'h07;
        bus.clear_start = 1'b1;
        @(negedge clk);
        bus.clear_start = 1'b0;
        push(17'd1000, 8'h22);
        for (int i = 0; i < 7; i++) push(17'(60000 + i), 8'(8'h40 + i));
        chk("hz_full_ready", bus.host_ready, 0);
        chk("hz_full_level", fifo_level, 8);
        bus.host_valid = 1'b1;
        bus.host_addr  = 17'd60007;
        bus.host_data  = 8'h47;
        repeat (4) @(negedge clk);
        chk("hz_held_ready", bus.host_ready, 0);
        chk("hz_held_level", fifo_level, 8);
        push(17'd60007, 8'h47);
        for (int i = 0; i < 80000 && !bus.clear_done; i++) @(negedge clk);
        chk("clr_done", bus.clear_done, 1);
        chk("clr_busy_fall", bus.clear_busy, 0);
        @(negedge clk);
        chk("clr_done_pulse", bus.clear_done, 0);
        #1 chk("clr_total_writes", wcnt - w0, 72010);
        chk("clr_seq", seq_bad, 0);
        chk("clr_count", exp_clr, 72000);
        chk("clr_done_count", done_cnt, 1);
        chk("hz_50_latency", t50 - tp, 1);
        chk("hz_1000_after_clear", h1000_late, 1);
        chk("mem_50", fbm[50], 8'h11);
        chk("mem_1000", fbm[1000], 8'h22);
        for (int i = 0; i < 8; i++) chk("mem_60000", fbm[60000 + i], 8'(8'h40 + i));
        bad = 0;
        for (int i = 0; i < 72000; i++)
            if (!(i == 50 || i == 1000 || (i >= 60000 && i < 60008)) && fbm[i] != 8'h03) bad++;
        chk("clr_fill", bad, 0);
        seq_on = 1'b0;
        bus.clear_color = 8'h05;
        bus.clear_start = 1'b1;
        @(negedge clk);
        bus.clear_start = 1'b0;
        repeat (10) @(negedge clk);
        push(17'd70000, 8'h66);
        chk("mid_level", fifo_level, 1);
        @(negedge clk);
        #1 w1 = wcnt;
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_we", bus.mem_we, 0);
        chk("mid_rst_busy", bus.clear_busy, 0);
        chk("mid_rst_level", fifo_level, 0);
        chk("mid_rst_oor", oor_cnt, 0);
        chk("mid_rst_ready", bus.host_ready, 1);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        #1 chk("mid_no_write", wcnt, w1);
        chk("mid_mem_70000", fbm[70000], 8'h03);
        chk("mid_idle", bus.clear_busy, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
